// File: rtl/sfm_pkg.sv
// Shared types for the softmax integer input path: FP formats, cast control
// and the unpacker state encoding.
package sfm_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic enable;
    } cast_ctrl_t;

    typedef enum logic {
        UNPACK_IDLE,
        UNPACK_SPLIT
    } unpack_state_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

    // Number of sub-beats one packed integer beat expands into.
    function automatic int unsigned unpack_ratio(fp_format_e fmt, int unsigned int_width);
        int unsigned w;
        w = fp_width(fmt);
        return (int_width >= w) ? 1 : w / int_width;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/sfm_int_unpacker.sv
// Splits one packed-integer beat into RATIO narrower sub-beats for the int->FP
// cast, dropping trailing chunks with no strobes set.
module sfm_int_unpacker
    import sfm_pkg::*;
#(
    parameter int unsigned DATA_W      = 160,
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter fp_format_e  FPFORMAT_IN = FP16ALT,
    parameter fp_format_e  FPFORMAT    = FPFORMAT_IN,
    parameter int unsigned INT_W       = 8,
    parameter int unsigned INT_WIDTH   = INT_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  cast_ctrl_t                    ctrl_i,
    hwpe_stream_intf_stream.sink          stream_i,
    hwpe_stream_intf_stream.source        stream_o
);

    localparam int unsigned ACTUAL_DW = DATA_WIDTH - 32;
    localparam int unsigned STRB_W    = ACTUAL_DW / 8;
    localparam int unsigned RATIO     = unpack_ratio(FPFORMAT, INT_WIDTH);
    localparam int unsigned CHUNK_W   = ACTUAL_DW / RATIO;
    localparam int unsigned CHUNK_B   = CHUNK_W / 8;
    localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    unpack_state_e          state, next_state;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [ACTUAL_DW-1:0]   buf_data;
    logic [STRB_W-1:0]      buf_strb;
    logic [RATIO-1:0]       tail_any;
    logic [CHUNK_W-1:0]     chunk_data;
    logic [CHUNK_B-1:0]     chunk_strb;
    logic                   last;
    logic                   load;
    logic                   flush;
    logic                   bypass;

    assign flush  = rst_i | clear_i;
    assign bypass = (RATIO == 1) || (state == UNPACK_IDLE && !ctrl_i.enable);

    assign chunk_data = buf_data[cnt*CHUNK_W +: CHUNK_W];
    assign chunk_strb = buf_strb[cnt*CHUNK_B +: CHUNK_B];

    // tail_any[i]: some chunk above i still carries strobes
    always_comb begin
        tail_any = '0;
        for (int i = int'(RATIO) - 2; i >= 0; i--)
            tail_any[i] = tail_any[i+1] | (|buf_strb[(i+1)*CHUNK_B +: CHUNK_B]);
    end

    assign last = (cnt == CNT_W'(RATIO - 1)) || !tail_any[cnt];

    always_comb begin
        stream_o.valid = 1'b0;
        stream_o.data  = '0;
        stream_o.strb  = '0;
        stream_i.ready = 1'b0;
        next_state     = state;
        cnt_n          = cnt;
        load           = 1'b0;
        if (flush) begin
            // outputs held quiet; the register block performs the reset
        end else if (bypass) begin
            stream_o.valid = stream_i.valid;
            stream_o.data  = stream_i.data;
            stream_o.strb  = stream_i.strb;
            stream_i.ready = stream_o.ready;
        end else if (state == UNPACK_IDLE) begin
            stream_i.ready = 1'b1;
            if (stream_i.valid) begin
                load       = 1'b1;
                next_state = UNPACK_SPLIT;
                cnt_n      = '0;
            end
        end else begin
            stream_o.valid                = 1'b1;
            stream_o.data[CHUNK_W-1:0]    = chunk_data;
            stream_o.strb[CHUNK_B-1:0]    = chunk_strb;
            stream_i.ready                = last & stream_o.ready & ctrl_i.enable;
            if (stream_o.ready) begin
                if (!last) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    cnt_n      = '0;
                    next_state = UNPACK_IDLE;
                end
                // back-to-back reload keeps the output bubble-free
                if (stream_i.valid && stream_i.ready) begin
                    load       = 1'b1;
                    next_state = UNPACK_SPLIT;
                    cnt_n      = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state    <= UNPACK_IDLE;
            cnt      <= '0;
            buf_data <= '0;
            buf_strb <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_n;
            if (load) begin
                buf_data <= stream_i.data[ACTUAL_DW-1:0];
                buf_strb <= stream_i.strb[STRB_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sfm_int_unpacker.sv
// Scoreboard bench for sfm_int_unpacker: BF16 target, 8-bit ints, 160-bit stream.
module tb_sfm_int_unpacker;
    import sfm_pkg::*;

    localparam int DW    = 160;
    localparam int SW    = DW / 8;
    localparam int ADW   = DW - 32;
    localparam int RATIO = 16 / 8;
    localparam int CHUNK = ADW / RATIO;
    localparam int CB    = CHUNK / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst, clear;
    cast_ctrl_t ctrl;
    beat_t      exp_q[$];
    beat_t      mon_e;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         rand_rdy = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if ();

    sfm_int_unpacker #(
        .DATA_WIDTH (DW),
        .FPFORMAT   (FP16ALT),
        .INT_WIDTH  (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .ctrl_i   (ctrl),
        .stream_i (in_if),
        .stream_o (out_if)
    );

    function automatic void chk(string name, logic [179:0] act, logic [179:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: split mode emits chunks up to the highest one holding a strobe
    // (at least one); passthrough forwards the beat untouched.
    function automatic void push_exp(logic [DW-1:0] d, logic [SW-1:0] s, logic en);
        beat_t e;
        int hi, n;
        if (!en) begin
            e.data = d;
            e.strb = s;
            exp_q.push_back(e);
            return;
        end
        hi = -1;
        for (int b = 0; b < ADW/8; b++) if (s[b]) hi = b;
        n = (hi < 0) ? 1 : hi / CB + 1;
        for (int k = 0; k < n; k++) begin
            e.data = '0;
            e.strb = '0;
            e.data[CHUNK-1:0] = d[k*CHUNK +: CHUNK];
            e.strb[CB-1:0]    = s[k*CB +: CB];
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit done;
        done = 0;
        in_if.data  = d;
        in_if.strb  = s;
        in_if.valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_if.ready) begin
                push_exp(d, s, ctrl.enable);
                done = 1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got ready=0 for 300 cycles expected acceptance");
            in_if.valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !clear && out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data=%h strb=%h expected no output",
                             out_if.data, out_if.strb);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sub_beat", {out_if.data, out_if.strb}, {mon_e.data, mon_e.strb});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_if.ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        logic [DW-1:0] d, d0;
        logic [SW-1:0] s;
        rst = 1'b1; clear = 1'b0; ctrl.enable = 1'b1;
        in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '0;
        out_if.ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_valid", out_if.valid, 0);
        chk("rst_ready", in_if.ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); #2;
        chk("idle_ready", in_if.ready, 1);
        chk("idle_valid", out_if.valid, 0);
        chk("idle_cnt", dut.cnt, 0);
        chk("idle_buf", dut.buf_data, 0);
        @(posedge clk); #1;

        // 1. basic split, byte i = i
        out_if.ready = 1'b1;
        d = '0;
        for (int b = 0; b < 16; b++) d[b*8 +: 8] = 8'(b);
        fork
            send(d, 20'h0FFFF);
            begin @(negedge clk); #2; chk("latency_no_bypass", out_if.valid, 0); end
        join
        in_if.valid = 1'b0;
        @(negedge clk); #2;
        chk("basic_sb0", {out_if.data, out_if.strb}, {96'h0, 64'h0706050403020100, 12'h0, 8'hFF});
        @(negedge clk); #2;
        chk("basic_sb1", {out_if.data, out_if.strb}, {96'h0, 64'h0F0E0D0C0B0A0908, 12'h0, 8'hFF});
        idle(2);

        // 2. tail drop
        send(rnd_data(), 20'h000FF);
        in_if.valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #2;
        chk("tail_ready", in_if.ready, 1);
        chk("tail_valid", out_if.valid, 0);
        chk("tail_state", dut.state == UNPACK_IDLE, 1);
        idle(2);

        // 3. streaming: 4 beats, no bubbles
        fork
            begin
                for (int k = 0; k < 4; k++) send(rnd_data(), 20'hFFFFF);
                in_if.valid = 1'b0;
            end
            begin
                @(posedge clk);
                for (int c = 1; c <= 8; c++) begin
                    @(negedge clk); #2;
                    chk("stream_valid", out_if.valid, 1);
                    if (c <= 7) chk("stream_ready", in_if.ready, (c % 2) == 0);
                end
            end
        join
        idle(3);

        // 4. backpressure on sub-beat 0
        out_if.ready = 1'b0;
        d = rnd_data();
        send(d, 20'h0FFFF);
        in_if.valid = 1'b0;
        d0 = '0;
        d0[CHUNK-1:0] = d[CHUNK-1:0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #2;
            chk("bp_valid", out_if.valid, 1);
            chk("bp_hold", {out_if.data, out_if.strb}, {d0, 20'h000FF});
            chk("bp_cnt", dut.cnt, 0);
        end
        @(posedge clk); #1; out_if.ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        d0[CHUNK-1:0] = d[2*CHUNK-1:CHUNK];
        chk("bp_sb1", {out_if.data, out_if.strb}, {d0, 20'h000FF});
        idle(2);

        // 5A. passthrough when disabled in IDLE
        ctrl.enable = 1'b0;
        out_if.ready = 1'b0;
        d = rnd_data();
        s = 20'($urandom());
        in_if.data = d; in_if.strb = s; in_if.valid = 1'b1;
        @(negedge clk); #2;
        chk("pass_out", {out_if.valid, out_if.data, out_if.strb}, {1'b1, d, s});
        chk("pass_ready", in_if.ready, 0);
        @(posedge clk); #1;
        out_if.ready = 1'b1;
        send(d, s);
        idle(1);

        // 5B. enable drops mid-split; next beat passes through afterwards
        ctrl.enable = 1'b1;
        send(rnd_data(), 20'hFFFFF);
        ctrl.enable = 1'b0;
        send(rnd_data(), 20'($urandom()));
        idle(2);
        ctrl.enable = 1'b1;

        // 6. reset / clear mid-split
        for (int v = 0; v < 2; v++) begin
            send(rnd_data(), 20'h0FFFF);
            in_if.valid = 1'b0;
            @(posedge clk); #1;
            if (v == 0) rst = 1'b1; else clear = 1'b1;
            exp_q.delete();
            @(negedge clk); #2;
            chk("flush_valid", out_if.valid, 0);
            chk("flush_ready", in_if.ready, 0);
            @(posedge clk); #1;
            rst = 1'b0; clear = 1'b0;
            @(negedge clk); #2;
            chk("post_flush_valid", out_if.valid, 0);
            chk("post_flush_cnt", dut.cnt, 0);
            @(posedge clk); #1;
            send(rnd_data(), 20'h0FFFF);
            idle(3);
        end

        // randomized traffic
        rand_rdy = 1;
        for (int k = 0; k < 60; k++) begin
            ctrl.enable = ($urandom_range(0, 9) < 8);
            case ($urandom_range(0, 4))
                0: s = 20'h00000;
                1: s = 20'h000FF;
                2: s = 20'h0FF00;
                3: s = 20'h0FFFF;
                default: s = 20'($urandom());
            endcase
            s[19:16] = 4'($urandom());
            send(rnd_data(), s);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_if.valid = 1'b0;
        for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
